// File: rtl/food_spawner.sv
// food_spawner
// Turns the free-running random X/Y coordinate streams into a legal food cell.
// Each request waits for a fresh generator sample and range-checks it against
// the grid. It then asks the snake-body occupancy logic whether the cell is
// free. Rejected candidates are retried on later samples until a free cell is
// committed or the retry budget runs out.
//
// Ports:
//   Clk, reset            system clock, asynchronous active-high reset
//   i_rnd_x, i_rnd_y      random coordinate values from the generators
//   i_spawn_req           one-cycle request for a new food position
//   i_food_clear          food eaten; drops o_food_valid
//   o_occ_qx, o_occ_qy    queried cell column/row
//   o_occ_query_valid     occupancy query pending
//   i_occ_resp_valid      occupancy response strobe
//   i_occ_hit             cell occupied (qualified by i_occ_resp_valid)
//   o_food_x, o_food_y    committed food pixel position
//   o_food_valid          o_food_x/o_food_y hold a committed position
//   o_busy                request in progress
//   o_spawn_done          one-cycle pulse on commit
//   o_spawn_fail          one-cycle pulse on retry exhaustion
module food_spawner #(
  parameter int SAMPLE_PERIOD = 10,
  parameter int CELL_SHIFT    = 4,
  parameter int GRID_W        = 40,
  parameter int GRID_H        = 30,
  parameter int MAX_TRIES     = 31
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic [9:0] i_rnd_x,
  input  logic [9:0] i_rnd_y,
  input  logic       i_spawn_req,
  input  logic       i_food_clear,
  output logic [5:0] o_occ_qx,
  output logic [5:0] o_occ_qy,
  output logic       o_occ_query_valid,
  input  logic       i_occ_resp_valid,
  input  logic       i_occ_hit,
  output logic [9:0] o_food_x,
  output logic [9:0] o_food_y,
  output logic       o_food_valid,
  output logic       o_busy,
  output logic       o_spawn_done,
  output logic       o_spawn_fail
);

  localparam int              CNT_W       = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SAMPLE_PERIOD - 1);
  localparam logic [6:0]      GRID_W_L    = 7'(GRID_W);
  localparam logic [6:0]      GRID_H_L    = 7'(GRID_H);
  localparam logic [4:0]      MAX_TRIES_L = 5'(MAX_TRIES);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_WAIT_SAMPLE = 3'd1,
    S_CHECK       = 3'd2,
    S_QUERY       = 3'd3,
    S_COMMIT      = 3'd4,
    S_FAIL        = 3'd5
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_seen_wrap;
  logic [4:0]       r_tries;
  logic [5:0]       r_cand_x;
  logic [5:0]       r_cand_y;

  logic             w_sample;
  logic [9:0]       w_rx_shift;
  logic [9:0]       w_ry_shift;
  logic [5:0]       w_cand_x;
  logic [5:0]       w_cand_y;
  logic [15:0]      w_food_x_full;
  logic [15:0]      w_food_y_full;
  logic             w_out_of_grid;
  logic [4:0]       w_tries_inc;
  state_t           w_reject_state;

  // The generators refresh on the same cadence and reset together with this
  // counter, so counter==0 only marks a fresh value once a full period has
  // elapsed (the very first counter==0 after reset is stale).
  assign w_sample = (r_cnt == '0) && r_seen_wrap;

  assign w_rx_shift = i_rnd_x >> CELL_SHIFT;
  assign w_ry_shift = i_rnd_y >> CELL_SHIFT;
  assign w_cand_x   = w_rx_shift[5:0];
  assign w_cand_y   = w_ry_shift[5:0];

  assign w_food_x_full = {10'd0, r_cand_x} << CELL_SHIFT;
  assign w_food_y_full = {10'd0, r_cand_y} << CELL_SHIFT;

  assign w_out_of_grid = ({1'b0, r_cand_x} >= GRID_W_L) || ({1'b0, r_cand_y} >= GRID_H_L);

  // A rejection either retries on the next sample or gives up once the
  // incremented count reaches the budget.
  assign w_tries_inc    = r_tries + 5'd1;
  assign w_reject_state = (w_tries_inc == MAX_TRIES_L) ? S_FAIL : S_WAIT_SAMPLE;

  // Free-running sample-phase counter with first-wrap flag.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_seen_wrap <= 1'b0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt       <= '0;
      r_seen_wrap <= 1'b1;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Request FSM with registered query, food and status outputs.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_state           <= S_IDLE;
      r_tries           <= 5'd0;
      r_cand_x          <= 6'd0;
      r_cand_y          <= 6'd0;
      o_occ_qx          <= 6'd0;
      o_occ_qy          <= 6'd0;
      o_occ_query_valid <= 1'b0;
      o_food_x          <= 10'd0;
      o_food_y          <= 10'd0;
      o_food_valid      <= 1'b0;
      o_busy            <= 1'b0;
      o_spawn_done      <= 1'b0;
      o_spawn_fail      <= 1'b0;
    end else begin
      o_spawn_done <= 1'b0;
      o_spawn_fail <= 1'b0;
      // A commit below overrides this, so a clear landing on COMMIT loses.
      if (i_food_clear) begin
        o_food_valid <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (i_spawn_req) begin
            r_state <= S_WAIT_SAMPLE;
            o_busy  <= 1'b1;
            r_tries <= 5'd0;
          end
        end
        S_WAIT_SAMPLE: begin
          if (w_sample) begin
            r_cand_x <= w_cand_x;
            r_cand_y <= w_cand_y;
            r_state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_out_of_grid) begin
            r_tries <= w_tries_inc;
            r_state <= w_reject_state;
          end else begin
            o_occ_qx          <= r_cand_x;
            o_occ_qy          <= r_cand_y;
            o_occ_query_valid <= 1'b1;
            r_state           <= S_QUERY;
          end
        end
        S_QUERY: begin
          if (i_occ_resp_valid) begin
            o_occ_query_valid <= 1'b0;
            if (i_occ_hit) begin
              r_tries <= w_tries_inc;
              r_state <= w_reject_state;
            end else begin
              r_state <= S_COMMIT;
            end
          end
        end
        S_COMMIT: begin
          o_food_x     <= w_food_x_full[9:0];
          o_food_y     <= w_food_y_full[9:0];
          o_food_valid <= 1'b1;
          o_spawn_done <= 1'b1;
          o_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
        S_FAIL: begin
          o_spawn_fail <= 1'b1;
          o_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          o_occ_query_valid <= 1'b0;
          o_busy            <= 1'b0;
          r_state           <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_food_spawner.sv
module tb_food_spawner;

  logic       Clk;
  logic       reset;
  logic [9:0] i_rnd_x;
  logic [9:0] i_rnd_y;
  logic       i_spawn_req;
  logic       i_food_clear;
  logic [5:0] o_occ_qx;
  logic [5:0] o_occ_qy;
  logic       o_occ_query_valid;
  logic       i_occ_resp_valid;
  logic       i_occ_hit;
  logic [9:0] o_food_x;
  logic [9:0] o_food_y;
  logic       o_food_valid;
  logic       o_busy;
  logic       o_spawn_done;
  logic       o_spawn_fail;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int done_cnt = 0, fail_cnt = 0, q_rises = 0, q_bad63 = 0, q_unstable = 0;
  logic       prev_qv = 1'b0;
  logic [5:0] q_hold_x, q_hold_y;

  int lag = 0, n_hits = 0, resp_cnt = 0, wait_cnt = 0;

  food_spawner dut (
    .Clk(Clk), .reset(reset),
    .i_rnd_x(i_rnd_x), .i_rnd_y(i_rnd_y),
    .i_spawn_req(i_spawn_req), .i_food_clear(i_food_clear),
    .o_occ_qx(o_occ_qx), .o_occ_qy(o_occ_qy), .o_occ_query_valid(o_occ_query_valid),
    .i_occ_resp_valid(i_occ_resp_valid), .i_occ_hit(i_occ_hit),
    .o_food_x(o_food_x), .o_food_y(o_food_y), .o_food_valid(o_food_valid),
    .o_busy(o_busy), .o_spawn_done(o_spawn_done), .o_spawn_fail(o_spawn_fail)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Cycle index since reset release; equals the DUT's sample-counter phase.
  initial begin
    forever begin
      @(posedge Clk);
      if (reset) cyc = 0;
      else       cyc = cyc + 1;
    end
  end

  // Event monitor: pulses, query rises, query stability, out-of-grid queries.
  initial begin
    forever begin
      @(negedge Clk);
      if (o_spawn_done) done_cnt++;
      if (o_spawn_fail) fail_cnt++;
      if (o_occ_query_valid) begin
        if (!prev_qv) begin
          q_rises++;
          q_hold_x = o_occ_qx;
          q_hold_y = o_occ_qy;
        end else if (o_occ_qx !== q_hold_x || o_occ_qy !== q_hold_y) begin
          q_unstable++;
        end
        if (o_occ_qx == 6'd63) q_bad63++;
      end
      prev_qv = o_occ_query_valid;
    end
  end

  // Occupancy responder: answers after 'lag' query cycles, hit for the first n_hits answers.
  initial begin
    i_occ_resp_valid = 1'b0;
    i_occ_hit        = 1'b0;
    forever begin
      @(negedge Clk);
      if (o_occ_query_valid) begin
        if (wait_cnt == lag) begin
          i_occ_resp_valid = 1'b1;
          i_occ_hit        = (resp_cnt < n_hits);
          resp_cnt++;
          wait_cnt = 0;
        end else begin
          i_occ_resp_valid = 1'b0;
          wait_cnt++;
        end
      end else begin
        i_occ_resp_valid = 1'b0;
        i_occ_hit        = 1'b0;
        wait_cnt         = 0;
      end
    end
  end

  task automatic clear_stats();
    done_cnt = 0; fail_cnt = 0; q_rises = 0; q_bad63 = 0; q_unstable = 0; resp_cnt = 0;
  endtask

  // Step to the next negedge whose cycle is a sample phase (cycle%10==0, >=20).
  task automatic align();
    @(negedge Clk);
    for (int i = 0; i < 40 && !((cyc % 10 == 0) && (cyc >= 20)); i++) @(negedge Clk);
  endtask

  task automatic pulse_req();
    i_spawn_req = 1'b1;
    @(negedge Clk);
    i_spawn_req = 1'b0;
  endtask

  task automatic wait_until(input int c);
    for (int i = 0; i < 500 && cyc != c; i++) @(negedge Clk);
  endtask

  task automatic run_until_done(input int limit, output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < limit; i++) begin
      if (o_spawn_done || o_spawn_fail) begin
        at_cyc = cyc;
        break;
      end
      @(negedge Clk);
    end
    if (at_cyc < 0) begin
      n_cmp++; n_fail++;
      $display("FAIL timeout: no spawn_done/spawn_fail within %0d cycles", limit);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge Clk);
    n_cmp++; if (o_food_x !== 10'd0)       begin n_fail++; $display("FAIL rst_food_x: got %0d want 0", o_food_x); end
    n_cmp++; if (o_food_y !== 10'd0)       begin n_fail++; $display("FAIL rst_food_y: got %0d want 0", o_food_y); end
    n_cmp++; if (o_food_valid !== 1'b0)    begin n_fail++; $display("FAIL rst_food_valid: got %b want 0", o_food_valid); end
    n_cmp++; if (o_busy !== 1'b0)          begin n_fail++; $display("FAIL rst_busy: got %b want 0", o_busy); end
    n_cmp++; if (o_spawn_done !== 1'b0 || o_spawn_fail !== 1'b0) begin n_fail++; $display("FAIL rst_pulses: got %b%b want 00", o_spawn_done, o_spawn_fail); end
    n_cmp++; if (o_occ_query_valid !== 1'b0 || o_occ_qx !== 6'd0 || o_occ_qy !== 6'd0) begin n_fail++; $display("FAIL rst_query: got v=%b x=%0d y=%0d want 0", o_occ_query_valid, o_occ_qx, o_occ_qy); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int b, at;
    i_rnd_x = 10'h0A5; i_rnd_y = 10'h123; lag = 0; n_hits = 0;
    clear_stats();
    wait_until(20);
    b = cyc;
    pulse_req();
    n_cmp++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise: got %b want 1", o_busy); end
    run_until_done(40, at);
    n_cmp++; if (at !== b + 14) begin n_fail++; $display("FAIL basic_latency: done at cycle %0d want %0d", at, b + 14); end
    n_cmp++; if (o_spawn_done !== 1'b1 || o_busy !== 1'b0) begin n_fail++; $display("FAIL basic_done_busy: got done=%b busy=%b want 1/0", o_spawn_done, o_busy); end
    n_cmp++; if (o_food_x !== 10'd160 || o_food_y !== 10'd288) begin n_fail++; $display("FAIL basic_food: got (%0d,%0d) want (160,288)", o_food_x, o_food_y); end
    n_cmp++; if (o_food_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", o_food_valid); end
    @(negedge Clk);
    n_cmp++; if (o_spawn_done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width: got %b want 0", o_spawn_done); end
    #1;
    n_cmp++; if (done_cnt !== 1 || q_rises !== 1) begin n_fail++; $display("FAIL basic_counts: got done=%0d queries=%0d want 1/1", done_cnt, q_rises); end
  endtask

  task automatic test_out_of_range();
    int b, at;
    i_rnd_x = 10'h3F0; i_rnd_y = 10'h040; lag = 0; n_hits = 0;
    clear_stats();
    align();
    b = cyc;
    pulse_req();
    wait_until(b + 12);
    i_rnd_x = 10'h050;
    run_until_done(40, at);
    n_cmp++; if (at !== b + 24) begin n_fail++; $display("FAIL oor_latency: done at cycle %0d want %0d", at, b + 24); end
    n_cmp++; if (o_food_x !== 10'd80 || o_food_y !== 10'd64) begin n_fail++; $display("FAIL oor_food: got (%0d,%0d) want (80,64)", o_food_x, o_food_y); end
    n_cmp++; if (dut.r_tries !== 5'd1) begin n_fail++; $display("FAIL oor_tries: got %0d want 1", dut.r_tries); end
    @(negedge Clk); #1;
    n_cmp++; if (q_bad63 !== 0 || q_rises !== 1) begin n_fail++; $display("FAIL oor_queries: got cell63=%0d queries=%0d want 0/1", q_bad63, q_rises); end
  endtask

  task automatic test_occupied(input int l, input int exp_off);
    int b, at;
    i_rnd_x = 10'h0A5; i_rnd_y = 10'h123; lag = l; n_hits = 3;
    clear_stats();
    align();
    b = cyc;
    pulse_req();
    run_until_done(80, at);
    n_cmp++; if (at !== b + exp_off) begin n_fail++; $display("FAIL occ_latency_lag%0d: done at cycle %0d want %0d", l, at, b + exp_off); end
    n_cmp++; if (o_spawn_done !== 1'b1 || o_food_x !== 10'd160 || o_food_y !== 10'd288) begin n_fail++; $display("FAIL occ_commit_lag%0d: got done=%b (%0d,%0d) want 1 (160,288)", l, o_spawn_done, o_food_x, o_food_y); end
    @(negedge Clk); #1;
    n_cmp++; if (q_rises !== 4 || resp_cnt !== 4) begin n_fail++; $display("FAIL occ_queries_lag%0d: got rises=%0d resps=%0d want 4/4", l, q_rises, resp_cnt); end
    n_cmp++; if (q_unstable !== 0) begin n_fail++; $display("FAIL occ_stable_lag%0d: got %0d unstable cycles want 0", l, q_unstable); end
  endtask

  task automatic test_exhaustion();
    int b, at;
    i_rnd_x = 10'h0A5; i_rnd_y = 10'h123; lag = 0; n_hits = 1000;
    clear_stats();
    align();
    b = cyc;
    pulse_req();
    run_until_done(400, at);
    n_cmp++; if (at !== b + 314) begin n_fail++; $display("FAIL exh_latency: fail at cycle %0d want %0d", at, b + 314); end
    n_cmp++; if (o_spawn_fail !== 1'b1 || o_spawn_done !== 1'b0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL exh_pulse: got fail=%b done=%b busy=%b want 1/0/0", o_spawn_fail, o_spawn_done, o_busy); end
    n_cmp++; if (o_food_x !== 10'd160 || o_food_y !== 10'd288 || o_food_valid !== 1'b1) begin n_fail++; $display("FAIL exh_food: got (%0d,%0d) v=%b want (160,288) v=1", o_food_x, o_food_y, o_food_valid); end
    repeat (3) @(negedge Clk); #1;
    n_cmp++; if (q_rises !== 31 || done_cnt !== 0 || fail_cnt !== 1) begin n_fail++; $display("FAIL exh_counts: got queries=%0d done=%0d fail=%0d want 31/0/1", q_rises, done_cnt, fail_cnt); end
  endtask

  task automatic test_req_and_clear();
    int b;
    i_food_clear = 1'b1;
    @(negedge Clk);
    i_food_clear = 1'b0;
    n_cmp++; if (o_food_valid !== 1'b0) begin n_fail++; $display("FAIL clr_idle: got %b want 0", o_food_valid); end
    i_rnd_x = 10'h0A5; i_rnd_y = 10'h123; lag = 0; n_hits = 0;
    clear_stats();
    align();
    b = cyc;
    pulse_req();
    wait_until(b + 5);
    pulse_req();
    wait_until(b + 13);
    i_food_clear = 1'b1;
    @(negedge Clk);
    i_food_clear = 1'b0;
    n_cmp++; if (o_spawn_done !== 1'b1 || o_food_valid !== 1'b1) begin n_fail++; $display("FAIL clr_commit: got done=%b valid=%b want 1/1", o_spawn_done, o_food_valid); end
    repeat (25) @(negedge Clk); #1;
    n_cmp++; if (done_cnt !== 1 || o_busy !== 1'b0 || o_food_valid !== 1'b1) begin n_fail++; $display("FAIL req_ignored: got done=%0d busy=%b valid=%b want 1/0/1", done_cnt, o_busy, o_food_valid); end
  endtask

  task automatic test_reset_mid_query();
    int b, at;
    i_rnd_x = 10'h0A5; i_rnd_y = 10'h123; lag = 100; n_hits = 0;
    clear_stats();
    align();
    b = cyc;
    pulse_req();
    wait_until(b + 14);
    n_cmp++; if (o_occ_query_valid !== 1'b1) begin n_fail++; $display("FAIL rmq_pending: got %b want 1", o_occ_query_valid); end
    reset = 1'b1;
    #1;
    n_cmp++; if (o_occ_query_valid !== 1'b0 || o_busy !== 1'b0 || o_food_valid !== 1'b0) begin n_fail++; $display("FAIL rmq_async: got qv=%b busy=%b valid=%b want 0/0/0", o_occ_query_valid, o_busy, o_food_valid); end
    n_cmp++; if (o_food_x !== 10'd0 || o_food_y !== 10'd0 || o_occ_qx !== 6'd0 || o_occ_qy !== 6'd0) begin n_fail++; $display("FAIL rmq_values: got food (%0d,%0d) q (%0d,%0d) want zeros", o_food_x, o_food_y, o_occ_qx, o_occ_qy); end
    repeat (2) @(negedge Clk);
    reset = 1'b0;
    lag = 0;
    #1;
    n_cmp++; if (done_cnt !== 0 || fail_cnt !== 0) begin n_fail++; $display("FAIL rmq_no_pulse: got done=%0d fail=%0d want 0/0", done_cnt, fail_cnt); end
    clear_stats();
    align();
    b = cyc;
    pulse_req();
    run_until_done(40, at);
    n_cmp++; if (at !== b + 14) begin n_fail++; $display("FAIL rmq_after_latency: done at cycle %0d want %0d", at, b + 14); end
    n_cmp++; if (o_food_x !== 10'd160 || o_food_y !== 10'd288 || o_food_valid !== 1'b1) begin n_fail++; $display("FAIL rmq_after_food: got (%0d,%0d) v=%b want (160,288) v=1", o_food_x, o_food_y, o_food_valid); end
  endtask

  initial begin
    reset        = 1'b1;
    i_rnd_x      = 10'd0;
    i_rnd_y      = 10'd0;
    i_spawn_req  = 1'b0;
    i_food_clear = 1'b0;
    test_reset();
    test_basic();
    test_out_of_range();
    test_occupied(0, 44);
    test_occupied(5, 49);
    test_exhaustion();
    test_req_and_clear();
    test_reset_mid_query();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/food_spawner.md
# food_spawner

Consumes the free-running LFSR coordinate streams and turns them into a legal food position on the playfield grid. Each request samples fresh random X/Y values at the generators' refresh cadence and range-checks them against the grid. It then asks the snake-body occupancy logic whether the cell is free, retrying until it gets a free cell or hits a retry limit. It sits between the two random-coordinate generators and the game-state/sprite logic.

## Interface
- SAMPLE_PERIOD, 10: clocks between generator output refreshes; must match the generators' latch period
- CELL_SHIFT, 4: log2 of cell size in pixels (16 px cells)
- GRID_W, 40: legal cell columns, 0..GRID_W-1
- GRID_H, 30: legal cell rows, 0..GRID_H-1
- MAX_TRIES, 31: rejected candidates allowed per request before failing (≤31)
- Clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- rnd_x  in  10  X random value from generator
- rnd_y  in  10  Y random value from generator
- spawn_req  in  1  one-cycle request for a new food position
- food_clear  in  1  food eaten; drop food_valid
- occ_qx  out  6  queried cell column
- occ_qy  out  6  queried cell row
- occ_query_valid  out  1  occupancy query pending
- occ_resp_valid  in  1  occupancy response strobe
- occ_hit  in  1  cell occupied; qualified by occ_resp_valid
- food_x  out  10  food pixel X = cell_x << CELL_SHIFT
- food_y  out  10  food pixel Y = cell_y << CELL_SHIFT
- food_valid  out  1  food_x/food_y hold a committed position
- busy  out  1  request in progress
- spawn_done  out  1  one-cycle pulse on commit
- spawn_fail  out  1  one-cycle pulse on retry exhaustion

## Operation
- Sample counter: free-running 0..SAMPLE_PERIOD-1, reset to 0 together with the generators. A seen_wrap flag is set on the first wrap. A sample cycle occurs when counter==0 and seen_wrap==1.
- Candidate: cand_x = rnd_x[9:CELL_SHIFT], cand_y = rnd_y[9:CELL_SHIFT], each truncated to 6 bits, captured only on a sample cycle.
- States:
  - IDLE: spawn_req -> WAIT_SAMPLE, set busy, clear tries.
  - WAIT_SAMPLE: on a sample cycle, capture the candidate -> CHECK.
  - CHECK: if cand_x ≥ GRID_W or cand_y ≥ GRID_H, reject; otherwise -> QUERY.
  - QUERY: drive occ_qx/occ_qy = candidate and occ_query_valid=1. Hold until occ_resp_valid.
    - Response with occ_hit=1: reject.
    - Response with occ_hit=0: -> COMMIT.
  - COMMIT: load food_x/food_y, set food_valid, pulse spawn_done, clear busy -> IDLE.
  - FAIL: pulse spawn_fail, clear busy -> IDLE. food_x/food_y/food_valid are unchanged.
- Reject: tries+1. If the new value equals MAX_TRIES -> FAIL; otherwise -> WAIT_SAMPLE. The next sample cycle is always used; the same sample is never reused.
- spawn_req while busy: ignored, not queued.
- food_clear: clears food_valid next cycle in any state. If food_clear coincides with COMMIT, COMMIT wins and food_valid=1.
- occ_resp_valid outside QUERY: ignored.
- Widths: tries 5 bits. food_x/food_y = {cand, CELL_SHIFT zeros} truncated to 10 bits.

## Timing
- Reset values: food_x=0, food_y=0, food_valid=0, busy=0, spawn_done=0, spawn_fail=0, occ_query_valid=0, occ_qx=0, occ_qy=0. State=IDLE, counter=0, seen_wrap=0, tries=0.
- Reset mid-request: returns to IDLE immediately. A pending occ_query_valid drops asynchronously and no pulse is emitted.
- busy rises the cycle after spawn_req is accepted.
- Wait for sample: 1..SAMPLE_PERIOD cycles after entering WAIT_SAMPLE.
- CHECK: 1 cycle.
- occ_query_valid: rises the cycle after CHECK and falls the cycle after occ_resp_valid. The response may arrive in the first query cycle, giving 1-cycle minimum query occupancy.
- Best-case latency from spawn_req to spawn_done: WAIT_SAMPLE + 1 (CHECK) + 1 (QUERY) + 1 (COMMIT).
- Each rejection costs SAMPLE_PERIOD cycles until the next sample cycle.
- spawn_done/spawn_fail: exactly one cycle, coincident with busy falling. food_* are updated on the same edge as spawn_done.

## Test plan
- Reset, then hold rnd_x=10'h0A5, rnd_y=10'h123, spawn_req at cycle 20, occ_hit=0 with same-cycle response -> food_x=160, food_y=288, food_valid=1, one spawn_done pulse, busy low afterward.
- Out-of-range: rnd_x=10'h3F0 on the first sample, then 10'h050 on the next, rnd_y=10'h040 -> no query for cell 63. Query cell (5,4) -> food_x=80, food_y=64, tries ended at 1.
- Occupied: respond occ_hit=1 three times, then 0 -> exactly 4 queries, with spawn_done one sample period after the 3rd rejection. Delayed responses (5-cycle lag) hold occ_query_valid stable throughout.
- Exhaustion: occ_hit=1 always with prior food at (160,288) valid -> 31 queries, then spawn_fail pulse. Food is unchanged and still valid; spawn_done is never asserted.
- Request and clear handling: a second spawn_req while busy is ignored (one spawn_done only). food_clear in the same cycle as COMMIT leaves food_valid=1. food_clear while IDLE drops food_valid.
- Reset asserted during QUERY -> all outputs at reset values within the same cycle. A later spawn_req works normally.
